uart_rx_periph: RTL

//  UART receive peripheral feeding the CPU MEM stage over the memory-mapped peripheral bus.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_periph_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 42 ++++
 rtl/uart_rx_periph.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive peripheral: FSM states,
// register addresses and CON bit positions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic [31:0] ADDR_UART_RXD = 32'h4000_001C;
  localparam logic [31:0] ADDR_UART_CON = 32'h4000_0020;

  localparam int CON_VALID  = 0;
  localparam int CON_OVR    = 1;
  localparam int CON_FERR   = 2;
  localparam int CON_IRQEN  = 3;
  localparam int CON_FULL   = 4;
  localparam int CON_PERR   = 5;

  localparam int OVERSAMPLE = 16;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_periph_if.sv
// Memory-mapped peripheral bus between the CPU MEM stage (master) and the
// UART receive peripheral (slave), including the level interrupt line.
interface uart_rx_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;

  modport master (output rd, wr, addr, wdata, input rdata, irqout);
  modport slave  (input rd, wr, addr, wdata, output rdata, irqout);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_periph.sv
// UART receive peripheral: 16x oversampled 8N1 deframer, receive FIFO and RXD/CON
// registers. Define UART_RX_PARITY_EN to receive 8E1 frames with parity checking.
module uart_rx_periph
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            UART_RX,
  uart_rx_periph_if.slave bus
);
  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  logic             rx_p0, rx_p1, rx_p2;
  logic             fall, tick, samp;
  logic [DIV_W-1:0] div_cnt;
  rx_state_t        state;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_p1;
  logic             vld_p1, ferr_p1;
  logic             fifo_empty, fifo_full, fifo_pop;
  logic [7:0]       fifo_head;
  logic             con_wr, rd_rxd, ovr_set;
  logic             irq_en, ferr, ovr, perr, irq_q;
  logic [31:0]      rdata_c;
  logic             unused_wdata;

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous synced value for edge detect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= UART_RX;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall = rx_p2 & ~rx_p1;
  assign tick = (div_cnt == DIV_LAST);
  assign samp = tick && (tick_cnt == ((state == START) ? 4'd7 : 4'd15));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        div_cnt <= '0;
    else if (state == IDLE && fall)    div_cnt <= '0;
    else if (tick)                     div_cnt <= '0;
    else                               div_cnt <= div_cnt + DIV_W'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad, perr_p1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      vld_p1   <= 1'b0;
      ferr_p1  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad  <= 1'b0;
      perr_p1  <= 1'b0;
`endif
    end else begin
      vld_p1  <= 1'b0;
      ferr_p1 <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_p1 <= 1'b0;
`endif
      if (tick && state != IDLE) tick_cnt <= samp ? 4'd0 : tick_cnt + 4'd1;
      case (state)
        IDLE: if (fall) begin
          state    <= START;
          tick_cnt <= '0;
          bit_idx  <= '0;
`ifdef UART_RX_PARITY_EN
          par_bad  <= 1'b0;
`endif
        end
        START: if (samp) state <= rx_p1 ? IDLE : DATA;
        DATA: if (samp) begin
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (samp) begin
          state <= STOP;
          if (rx_p1 != even_parity(shift_p1)) begin
            par_bad <= 1'b1;
            perr_p1 <= 1'b1;
          end
        end
        STOP: if (samp) begin
          state <= IDLE;
          if (!rx_p1)        ferr_p1 <= 1'b1;
          else if (!par_bad) vld_p1  <= 1'b1;
        end
`else
        STOP: if (samp) begin
          state <= IDLE;
          if (!rx_p1) ferr_p1 <= 1'b1;
          else        vld_p1  <= 1'b1;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == DATA && samp) shift_p1 <= {rx_p1, shift_p1[7:1]};
  end

  // Stage p1 -> FIFO: the assembled byte is pushed the cycle after the stop sample.
  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (vld_p1),
    .pop   (fifo_pop),
    .wdata (shift_p1),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign con_wr   = bus.wr && (bus.addr == ADDR_UART_CON);
  assign rd_rxd   = bus.rd && (bus.addr == ADDR_UART_RXD);
  assign fifo_pop = rd_rxd & ~fifo_empty;
  assign ovr_set  = vld_p1 & fifo_full & ~fifo_pop;

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (con_wr) irq_en <= bus.wdata[CON_IRQEN];
      ferr  <= ferr_p1 | (ferr & ~(con_wr & bus.wdata[CON_FERR]));
      ovr   <= ovr_set | (ovr & ~(con_wr & bus.wdata[CON_OVR]));
      irq_q <= irq_en & ~fifo_empty;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) perr <= 1'b0;
    else        perr <= perr_p1 | (perr & ~(con_wr & bus.wdata[CON_PERR]));
  end
`else
  assign perr = 1'b0;
`endif

  always_comb begin
    rdata_c = '0;
    if (bus.rd) begin
      if (bus.addr == ADDR_UART_RXD)
        rdata_c = {24'b0, fifo_empty ? 8'h00 : fifo_head};
      else if (bus.addr == ADDR_UART_CON)
        rdata_c = {26'b0, perr, fifo_full, irq_en, ferr, ovr, ~fifo_empty};
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.irqout   = irq_q;
  assign unused_wdata = ^bus.wdata;

endmodule
